ex_muldiv_seq: RTL and testbench
================================

// Module: ex_muldiv_seq
// PURPOSE
// - Iterative RV32M multiply/divide unit with its own sequencer. It sits beside the ALU/CMP in the EX stage.
// - Accepts one M-op from EX and holds the pipeline via stall while it iterates.
// - Presents a 32-bit result for the EX->MEM register on its single DONE cycle.
// PARAMETERS
// - XLEN  32  operand/result width; iteration count = XLEN
// PORTS
// - clk         in   1     clock; all state on posedge
// - rst         in   1     asynchronous, active-high reset
// - req_valid   in   1     EX holds a valid M-op; held with op/a/b stable while stall=1
// - flush       in   1     branch/jump squash of the EX instruction
// - op          in   3     funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
// - a           in   XLEN  rs1 value (forwarded)
// - b           in   XLEN  rs2 value (forwarded)
// - stall       out  1     freeze IF/ID/EX and bubble MEM this cycle
// - busy        out  1     state != IDLE
// - resp_valid  out  1     result valid this cycle; EX->MEM may latch it
// - result      out  XLEN  registered result
// BEHAVIOUR
// - Reset (async): state=IDLE; all datapath regs=0. While rst=1: stall=0, busy=0, resp_valid=0, result=0.
// - States: IDLE, CALC, DONE.
//   - IDLE + req_valid + !flush, normal op:
//     - latch |a|, |b|, sign flags, op; cnt=0
//     - go to CALC
//   - IDLE + req_valid + !flush, special div/rem: latch final result, go to DONE.
//     - b==0: DIV/DIVU -> 0xFFFF_FFFF; REM/REMU -> a
//     - DIV/REM with a=0x8000_0000, b=0xFFFF_FFFF: DIV -> 0x8000_0000; REM -> 0
//   - CALC: one iteration per cycle; cnt++.
//     - On cnt==XLEN-1: apply sign correction, latch result, go to DONE.
//   - DONE: resp_valid=1 for exactly 1 cycle, then go to IDLE.
// - stall = req_valid & (state != DONE) & !flush & !rst.
//   - Combinational, so it is high in the accept cycle.
// - Latency seen by EX:
//   - normal op: 1 + XLEN + 1 = 34 cycles, stall high for the first 33
//   - special op: 2 cycles
// - Multiply: shift-add on magnitudes into a 2*XLEN product register.
//   - Negate the product if the operand signs differ.
//   - MUL takes [31:0]; MULH/MULHSU/MULHU take [63:32].
//   - Signedness: MULH a,b signed; MULHSU a signed, b unsigned; MULHU both unsigned.
// - Divide: restoring division on magnitudes, 1 quotient bit per cycle.
//   - Quotient sign = sa^sb; remainder sign = sa. Unsigned ops never negate.
// - Flush (sync, highest priority):
//   - In any state, flush=1 -> next state IDLE, result unchanged.
//   - resp_valid = (state==DONE) & !flush.
// - req_valid dropping in CALC without flush is illegal; the unit ignores it and finishes.
// - Back-to-back M-ops: the next op is accepted in the IDLE cycle after DONE. No op is ever accepted in DONE.
// - Reset mid-CALC: immediate return to IDLE. No resp_valid is produced for the aborted op.
// TESTING
// - MUL a=7, b=-3 (0xFFFF_FFFD) -> stall high 33 cycles; resp_valid in cycle 34; result=0xFFFF_FFEB.
// - MULHU a=b=0xFFFF_FFFF -> result=0xFFFF_FFFE. MULH a=0x8000_0000, b=0x8000_0000 -> 0x4000_0000.
// - MULHSU a=-1, b=2 -> result=0xFFFF_FFFF.
// - DIV a=-7, b=2 -> 0xFFFF_FFFD. REM a=-7, b=2 -> 0xFFFF_FFFF. DIVU a=100, b=7 -> 14. REMU -> 2.
// - DIV b=0 -> 0xFFFF_FFFF in 2 cycles. REM a=5, b=0 -> 5. DIV 0x8000_0000 / -1 -> 0x8000_0000. REM -> 0.
// - flush at CALC cnt=10 -> next cycle IDLE, busy=0, no resp_valid.
//   - New DIVU 9/3 then completes with result=3.
// - rst pulse mid-CALC (async, between edges) -> busy/stall/result drop to 0 immediately.
//   - Two back-to-back MULs after reset each take 34 cycles and produce correct results.

Source files
------------

// File: rtl/ex_muldiv_seq.sv
// ex_muldiv_seq: iterative RV32M multiply/divide unit that holds EX via stall while it iterates.
`timescale 1ns/1ps
module ex_muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic            flush,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            stall,
  output logic            busy,
  output logic            resp_valid,
  output logic [XLEN-1:0] result
);
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;
  logic [XLEN-1:0] m_q, m_d, res_q, res_d;
  logic [2*XLEN-1:0] p_q, p_d, p_nx, mp;
  logic [2:0] op_q, op_d;
  logic sq_q, sq_d, sr_q, sr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic sa, sb, na, nb, special, ge;
  logic [XLEN-1:0] abs_a, abs_b, spec_res, diff, hi, lo, fin;
  logic [XLEN:0] add_s;
  always_comb begin
    sa = op[2] ? !op[0] : (op[1:0] != 2'b11);
    sb = op[2] ? !op[0] : !op[1];
    na = sa & a[XLEN-1];
    nb = sb & b[XLEN-1];
    abs_a = na ? -a : a;
    abs_b = nb ? -b : b;
    special = op[2] & ((b == '0) | (!op[0] & (a == {1'b1, {(XLEN-1){1'b0}}}) & (b == '1)));
    // overflow case: a is already the most-negative value, which is the DIV answer
    spec_res = (b == '0) ? (op[1] ? a : '1) : (op[1] ? '0 : a);
  end
  always_comb begin
    add_s = {1'b0, p_q[2*XLEN-1:XLEN]} + {1'b0, p_q[0] ? m_q : '0};
    ge = p_q[2*XLEN-1:XLEN-1] >= {1'b0, m_q};
    diff = p_q[2*XLEN-2:XLEN-1] - m_q;
    p_nx = op_q[2] ? (ge ? {diff, p_q[XLEN-2:0], 1'b1} : {p_q[2*XLEN-2:0], 1'b0})
                   : {add_s, p_q[XLEN-1:1]};
    mp = sq_q ? -p_nx : p_nx;
    hi = p_nx[2*XLEN-1:XLEN];
    lo = p_nx[XLEN-1:0];
    fin = !op_q[2] ? ((op_q[1:0] == 2'b00) ? mp[XLEN-1:0] : mp[2*XLEN-1:XLEN])
                   : (op_q[1] ? (sr_q ? -hi : hi) : (sq_q ? -lo : lo));
  end
  always_comb begin
    state_d = state_q;
    m_d = m_q;
    p_d = p_q;
    op_d = op_q;
    sq_d = sq_q;
    sr_d = sr_q;
    cnt_d = cnt_q;
    res_d = res_q;
    if (flush) state_d = IDLE;
    else if (state_q == IDLE && req_valid) begin
      if (special) begin
        res_d = spec_res;
        state_d = DONE;
      end else begin
        m_d = op[2] ? abs_b : abs_a;
        p_d = {{XLEN{1'b0}}, op[2] ? abs_a : abs_b};
        op_d = op;
        sq_d = na ^ nb;
        sr_d = na;
        cnt_d = '0;
        state_d = CALC;
      end
    end else if (state_q == CALC) begin
      p_d = p_nx;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        res_d = fin;
        state_d = DONE;
      end
    end else if (state_q == DONE) state_d = IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      m_q <= '0;
      p_q <= '0;
      op_q <= '0;
      sq_q <= 1'b0;
      sr_q <= 1'b0;
      cnt_q <= '0;
      res_q <= '0;
    end else begin
      state_q <= state_d;
      m_q <= m_d;
      p_q <= p_d;
      op_q <= op_d;
      sq_q <= sq_d;
      sr_q <= sr_d;
      cnt_q <= cnt_d;
      res_q <= res_d;
    end
  end
  assign stall = req_valid & (state_q != DONE) & !flush & !rst;
  assign busy = state_q != IDLE;
  assign resp_valid = (state_q == DONE) & !flush;
  assign result = res_q;
endmodule

// File: tb/tb_ex_muldiv_seq.sv
// tb_ex_muldiv_seq: directed checks of the sequential RV32M unit against hand-computed results.
`timescale 1ns/1ps
module tb_ex_muldiv_seq;
  logic clk = 1'b0, rst = 1'b1, req_valid = 1'b0, flush = 1'b0;
  logic [2:0] op = '0;
  logic [31:0] a = '0, b = '0;
  logic stall, busy, resp_valid;
  logic [31:0] result;
  int n_cmp = 0, n_err = 0;
  ex_muldiv_seq #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .flush(flush), .op(op), .a(a), .b(b),
    .stall(stall), .busy(busy), .resp_valid(resp_valid), .result(result)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask
  // Called just after a posedge; counts cycles until resp_valid and the stall cycles before it.
  task automatic run(input string tag, input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] exp, input int lat);
    int cyc = 0, st = 0;
    bit got = 0;
    req_valid = 1'b1; op = o; a = x; b = y;
    while (!got && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (resp_valid) got = 1;
      else if (stall) st++;
    end
    chk({tag, "_lat"}, cyc, lat);
    chk({tag, "_stall"}, st, lat - 1);
    chk({tag, "_res"}, result, exp);
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask
  initial begin
    int rv;
    req_valid = 1'b1;
    #12;
    chk("rst_stall", {31'b0, stall}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_resp", {31'b0, resp_valid}, 0);
    chk("rst_result", result, 0);
    req_valid = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk) #1;
    run("mul", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 34);
    run("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34);
    run("mulh", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34);
    run("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 34);
    run("div", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    run("rem", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    run("divu", 3'b101, 32'd100, 32'd7, 32'd14, 34);
    run("remu", 3'b111, 32'd100, 32'd7, 32'd2, 34);
    run("div0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);
    run("rem0", 3'b110, 32'd5, 32'd0, 32'd5, 2);
    run("divu0", 3'b101, 32'd9, 32'd0, 32'hFFFF_FFFF, 2);
    run("remu0", 3'b111, 32'd7, 32'd0, 32'd7, 2);
    run("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
    run("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2);
    req_valid = 1'b1; op = 3'b100; a = 32'd1000; b = 32'd3;
    repeat (11) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    chk("flush_stall", {31'b0, stall}, 0);
    chk("flush_resp", {31'b0, resp_valid}, 0);
    @(posedge clk);
    #1 flush = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("flush_busy", {31'b0, busy}, 0);
    rv = 0;
    repeat (40) begin
      @(negedge clk);
      if (resp_valid) rv++;
    end
    chk("flush_no_resp", rv, 0);
    chk("flush_result_kept", result, 32'h8000_0000 ^ 32'h8000_0000);
    @(posedge clk) #1;
    run("divu_after_flush", 3'b101, 32'd9, 32'd3, 32'd3, 34);
    req_valid = 1'b1; op = 3'b000; a = 32'd11; b = 32'd13;
    repeat (6) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", {31'b0, busy}, 0);
    chk("arst_stall", {31'b0, stall}, 0);
    chk("arst_result", result, 0);
    chk("arst_resp", {31'b0, resp_valid}, 0);
    req_valid = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk) #1;
    run("mul_b2b_1", 3'b000, 32'd12345, 32'd678, 32'h007F_B6F6, 34);
    run("mul_b2b_2", 3'b000, 32'hFFFF_FFFE, 32'hFFFF_FFFC, 32'd8, 34);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
